a23_mem_arb: RTL and testbench

A23_MEM_ARB -- requirements
Module: a23_mem_arb

---
 rtl/a23_mini_sys_pkg.sv | 16 +
 rtl/a23_mem_arb_wdog.sv | 32 +++
 rtl/a23_mem_arb.sv | 171 +++++++++++++++++
 tb/tb_a23_mem_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/a23_mini_sys_pkg.sv
// Shared types and default widths for the a23 mini system bus blocks.
package a23_mini_sys_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_TO_CYC = 255;
    localparam int ARB_CNT_W  = 16;

    // Arbiter grant state; GNT0/GNT1 map directly onto the one-hot gnt_o bits.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/a23_mem_arb_wdog.sv
// Slave-ack watchdog: counts cycles a granted strobe waits without a response
// and flags expiry when the count reaches LIMIT.
module a23_mem_arb_wdog
    import a23_mini_sys_pkg::*;
#(
    parameter int LIMIT = ARB_TO_CYC
) (
    input  logic clk_i,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam logic [ARB_CNT_W-1:0] LIMIT_V = LIMIT[ARB_CNT_W-1:0];

    logic [ARB_CNT_W-1:0] cnt;

    // Wait counter: clear has priority, otherwise count up while run, holding at all-ones.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == LIMIT_V);

endmodule

// File: rtl/a23_mem_arb.sv
// Two-master Wishbone-style arbiter in front of a single slave port.
// m0 is the a23 core bus, m1 the loader/debug bus. A master owns the slave
// for as long as it holds cyc; contention from IDLE is resolved round robin.
//
// Handshake: a transfer is offered while the granted master holds stb high
// and completes in the cycle the slave returns ack (or err). The master must
// keep stb and its request fields stable until that cycle. A strobe that
// waits TO_CYC cycles without response is ended with a one-cycle err and
// stb is withdrawn from the slave for that cycle.
module a23_mem_arb
    import a23_mini_sys_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int TO_CYC = ARB_TO_CYC
) (
    input  logic                clk_i,
    input  logic                rstn,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    output logic [1:0]          gnt_o,
    output logic [15:0]         to_cnt_o
);

    arb_state_t state, state_nxt;
    logic       last_m1, last_m1_nxt;   // 1 when the most recent grant went to m1
    logic [1:0] rst_sync;
    logic       rst_ok;
    logic       gnt0, gnt1;
    logic       m_stb;
    logic       expire;
    logic       timeout;
    logic       resp_ack, resp_err;
    logic       wd_run, wd_clear;

    // Two-flop synchroniser on reset release; the FSM stays in IDLE until it settles.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_ok = rst_sync[1];

    // Grant state register and round-robin memory; reset favours m0 next.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state   <= ARB_IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            last_m1 <= last_m1_nxt;
        end
    end

    // Next grant: only IDLE may grant, so every hand-over passes through one IDLE cycle.
    always_comb begin
        state_nxt   = state;
        last_m1_nxt = last_m1;
        case (state)
            ARB_IDLE: begin
                if (rst_ok) begin
                    if (m0_cyc_i && (!m1_cyc_i || last_m1)) begin
                        state_nxt   = ARB_GNT0;
                        last_m1_nxt = 1'b0;
                    end else if (m1_cyc_i) begin
                        state_nxt   = ARB_GNT1;
                        last_m1_nxt = 1'b1;
                    end
                end
            end
            ARB_GNT0: if (!m0_cyc_i) state_nxt = ARB_IDLE;
            ARB_GNT1: if (!m1_cyc_i) state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    assign gnt0  = (state == ARB_GNT0);
    assign gnt1  = (state == ARB_GNT1);
    assign gnt_o = {gnt1, gnt0};

    // Timeout only counts when the slave gave no response this cycle (ack wins).
    assign m_stb    = (gnt0 & m0_stb_i) | (gnt1 & m1_stb_i);
    assign timeout  = m_stb & expire & ~s_ack_i & ~s_err_i;
    assign resp_err = m_stb & (s_err_i | timeout);
    assign resp_ack = m_stb & s_ack_i & ~s_err_i;
    assign wd_run   = m_stb & ~s_ack_i & ~s_err_i;
    assign wd_clear = ~m_stb | s_ack_i | s_err_i | timeout;

    a23_mem_arb_wdog #(
        .LIMIT (TO_CYC)
    ) u_wdog (
        .clk_i  (clk_i),
        .rstn   (rstn),
        .run    (wd_run),
        .clear  (wd_clear),
        .expire (expire)
    );

    // Slave-side mux: forward the granted master, drive zeros when idle.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~timeout;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~timeout;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // Master-side responses: only the granted master sees the slave.
    always_comb begin
        m0_ack_o = gnt0 & resp_ack;
        m0_err_o = gnt0 & resp_err;
        m1_ack_o = gnt1 & resp_ack;
        m1_err_o = gnt1 & resp_err;
        m0_dat_o = gnt0 ? s_dat_i : '0;
        m1_dat_o = gnt1 ? s_dat_i : '0;
    end

    // Saturating count of timeouts since reset.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            to_cnt_o <= '0;
        end else if (timeout && (to_cnt_o != 16'hFFFF)) begin
            to_cnt_o <= to_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_a23_mem_arb.sv
// Directed bench for a23_mem_arb with a hand-driven slave and TO_CYC = 8.
module tb_a23_mem_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;
    logic [15:0] to_cnt_o;

    int n_cmp = 0;
    int n_mis = 0;

    // Clock and time limit
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit: observed no finish, required finish before 200000");
        $fatal(1, "time limit");
    end

    a23_mem_arb #(
        .ADDR_W (32),
        .DATA_W (32),
        .TO_CYC (8)
    ) dut (
        .clk_i    (clk),
        .rstn     (rstn),
        .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i),
        .m0_we_i  (m0_we_i),
        .m0_sel_i (m0_sel_i),
        .m0_adr_i (m0_adr_i),
        .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i),
        .m1_we_i  (m1_we_i),
        .m1_sel_i (m1_sel_i),
        .m1_adr_i (m1_adr_i),
        .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .gnt_o    (gnt_o),
        .to_cnt_o (to_cnt_o)
    );

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with requests and a stray ack present
        rstn = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'h0;
        m0_adr_i = 32'h0; m0_dat_i = 32'h0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'h0;
        m1_adr_i = 32'h0; m1_dat_i = 32'h0;
        s_dat_i = 32'h0; s_ack_i = 1'b1; s_err_i = 1'b0;
        @(negedge clk);
        check("rst_gnt", gnt_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 1'b0);
        check("rst_s_stb", s_stb_o, 1'b0);
        check("rst_to_cnt", to_cnt_o, 16'h0);
        check("rst_m0_ack", m0_ack_o, 1'b0);
        check("rst_m0_err", m0_err_o, 1'b0);

        // Release with both masters contending; grant waits for the synchroniser
        next();
        rstn = 1'b1; m0_stb_i = 1'b0; s_ack_i = 1'b0;
        next(); @(negedge clk);
        check("sync_edge1_gnt", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("sync_edge2_gnt", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("first_contend_m0", gnt_o, 2'b01);

        // m0 releases: grant held until the edge, then one IDLE cycle, then m1
        next();
        m0_cyc_i = 1'b0;
        @(negedge clk);
        check("hold_until_edge", gnt_o, 2'b01);
        check("s_cyc_follows", s_cyc_o, 1'b0);
        next(); @(negedge clk);
        check("idle_gap", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("rr_m1", gnt_o, 2'b10);

        // Repeat contention -> m0
        next();
        m1_cyc_i = 1'b0;
        next();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        @(negedge clk);
        check("rr_idle_before", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("rr_repeat_m0", gnt_o, 2'b01);
        next();
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        next();

        // m0 single write, zero-wait slave
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h100; m0_dat_i = 32'hDEADBEEF;
        @(negedge clk);
        check("wr_idle_gnt", gnt_o, 2'b00);
        check("wr_idle_stb", s_stb_o, 1'b0);
        next();
        s_ack_i = 1'b1;
        @(negedge clk);
        check("wr_gnt", gnt_o, 2'b01);
        check("wr_s_adr", s_adr_o, 32'h100);
        check("wr_s_dat", s_dat_o, 32'hDEADBEEF);
        check("wr_s_we", s_we_o, 1'b1);
        check("wr_s_sel", s_sel_o, 4'hF);
        check("wr_s_stb", s_stb_o, 1'b1);
        check("wr_m0_ack", m0_ack_o, 1'b1);
        check("wr_m1_ack", m1_ack_o, 1'b0);
        next();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk);
        check("wr_ack_drop", m0_ack_o, 1'b0);

        // Late ack while idle is ignored
        next();
        s_ack_i = 1'b1;
        @(negedge clk);
        check("late_ack_m0", m0_ack_o, 1'b0);
        check("late_ack_m1", m1_ack_o, 1'b0);
        check("late_ack_gnt", gnt_o, 2'b00);

        // m1 locked across 4 reads while m0 waits
        s_ack_i = 1'b0;
        m1_cyc_i = 1'b1;
        next();
        m0_cyc_i = 1'b1;
        @(negedge clk);
        check("lock_gnt_m1", gnt_o, 2'b10);
        for (int i = 0; i < 4; i++) begin
            next();
            m1_stb_i = 1'b1; m1_adr_i = 32'h200 + 32'(4 * i);
            s_dat_i = 32'hA0000000 + 32'(i); s_ack_i = 1'b1;
            @(negedge clk);
            check($sformatf("rd%0d_ack", i), m1_ack_o, 1'b1);
            check($sformatf("rd%0d_dat", i), m1_dat_o, 32'hA0000000 + 32'(i));
            check($sformatf("rd%0d_adr", i), s_adr_o, 32'h200 + 32'(4 * i));
            check($sformatf("rd%0d_m0_ack", i), m0_ack_o, 1'b0);
            check($sformatf("rd%0d_m0_dat", i), m0_dat_o, 32'h0);
            next();
            m1_stb_i = 1'b0; s_ack_i = 1'b0;
            @(negedge clk);
            check($sformatf("rd%0d_gnt", i), gnt_o, 2'b10);
        end
        next();
        m1_cyc_i = 1'b0;
        @(negedge clk);
        check("unlock_hold", gnt_o, 2'b10);
        next(); @(negedge clk);
        check("unlock_idle", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("m0_after_lock", gnt_o, 2'b01);

        // Timeout: slave never responds, err pulses at cycle 8 of the strobe
        next();
        m0_stb_i = 1'b1; m0_adr_i = 32'h300;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            check($sformatf("to_err_k%0d", k), m0_err_o, (k == 8) ? 1'b1 : 1'b0);
            check($sformatf("to_stb_k%0d", k), s_stb_o, (k == 8) ? 1'b0 : 1'b1);
            next();
        end
        m0_stb_i = 1'b0;
        @(negedge clk);
        check("to_cnt_one", to_cnt_o, 16'd1);

        // Ack and err together -> err only
        next();
        m0_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
        @(negedge clk);
        check("both_err", m0_err_o, 1'b1);
        check("both_ack", m0_ack_o, 1'b0);
        next();
        m0_stb_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // Ack on the exact timeout cycle wins
        next();
        m0_stb_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("aw_err_k%0d", k), m0_err_o, 1'b0);
            next();
        end
        s_ack_i = 1'b1;
        @(negedge clk);
        check("aw_ack", m0_ack_o, 1'b1);
        check("aw_err", m0_err_o, 1'b0);
        check("aw_stb", s_stb_o, 1'b1);
        next();
        m0_stb_i = 1'b0; s_ack_i = 1'b0;
        @(negedge clk);
        check("aw_to_cnt", to_cnt_o, 16'd1);

        // Reset in the middle of an m1 transfer
        next();
        m0_cyc_i = 1'b0;
        next();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h400;
        next();
        @(negedge clk);
        check("mid_m1_cyc", s_cyc_o, 1'b1);
        #1;
        rstn = 1'b0; s_ack_i = 1'b1;
        #1;
        check("mid_rst_cyc", s_cyc_o, 1'b0);
        check("mid_rst_stb", s_stb_o, 1'b0);
        check("mid_rst_gnt", gnt_o, 2'b00);
        check("mid_rst_ack", m1_ack_o, 1'b0);
        next();
        next();
        rstn = 1'b1; s_ack_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        next(); @(negedge clk);
        check("rel_edge1_gnt", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("rel_edge2_gnt", gnt_o, 2'b00);
        next(); @(negedge clk);
        check("post_reset_m0", gnt_o, 2'b01);
        check("post_reset_to_cnt", to_cnt_o, 16'd0);

        next();
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        repeat (3) next();

        // Report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
